// File: rtl/nr_div_pkg.sv
// Shared definitions for the non-restoring sequential divider:
// FSM encodings, default operand width and the divide-by-zero quotient.
package nr_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    localparam int unsigned DEF_WIDTH = 32;

    localparam logic [DEF_WIDTH-1:0] DZ_QUOTIENT = '1;

endpackage : nr_div_pkg

// File: rtl/nr_div_step.sv
// One non-restoring iteration: shift {A,Q} left, add or subtract M by the
// pre-shift sign of A, and shift the new quotient bit into Q.
module nr_div_step
    import nr_div_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH:0]   a,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH:0]   a_nxt,
    output logic [WIDTH-1:0] q_nxt
);

    logic [WIDTH:0] a_sh;
    logic [WIDTH:0] m_ext;

    always_comb begin
        a_sh  = {a[WIDTH-1:0], q[WIDTH-1]};
        m_ext = {1'b0, m};
        // Arithmetic wraps modulo 2^(WIDTH+1); the sign bit carries the decision.
        a_nxt = a[WIDTH] ? (a_sh + m_ext) : (a_sh - m_ext);
        q_nxt = {q[WIDTH-2:0], ~a_nxt[WIDTH]};
    end

endmodule : nr_div_step

// File: rtl/nr_divider_seq.sv
// Iterative unsigned non-restoring divider, one quotient bit per clock,
// with a final remainder-correction step and registered results.
module nr_divider_seq
    import nr_div_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [WIDTH:0]   a;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] m;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   a_step;
    logic [WIDTH-1:0] q_step;
    logic [WIDTH:0]   a_corr;

    nr_div_step #(.WIDTH(WIDTH)) u_step (
        .a     (a),
        .q     (q),
        .m     (m),
        .a_nxt (a_step),
        .q_nxt (q_step)
    );

    always_comb begin
        a_corr = a + {1'b0, m};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && (divisor != '0)) state_nxt = RUN;
            RUN:     if (count == LAST) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a           <= '0;
            q           <= '0;
            m           <= '0;
            count       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            // Zero divisor resolves in IDLE without entering RUN.
                            done        <= 1'b1;
                            div_by_zero <= 1'b1;
                            quotient    <= WIDTH'(DZ_QUOTIENT);
                            remainder   <= dividend;
                        end else begin
                            m     <= divisor;
                            q     <= dividend;
                            a     <= '0;
                            count <= '0;
                            busy  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    a     <= a_step;
                    q     <= q_step;
                    count <= count + 1'b1;
                end
                FIX: begin
                    remainder   <= a[WIDTH] ? a_corr[WIDTH-1:0] : a[WIDTH-1:0];
                    quotient    <= q;
                    done        <= 1'b1;
                    div_by_zero <= 1'b0;
                    busy        <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule : nr_divider_seq

// File: tb/tb_nr_divider_seq.sv
// Self-checking bench for nr_divider_seq: directed corner cases plus random
// operands compared against plain integer division.
module tb_nr_divider_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int unsigned n_checks;
    int unsigned n_pass;

    nr_divider_seq #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Called away from a clock edge; returns #1 after the accepting edge.
    task automatic launch(input logic [31:0] dd, input logic [31:0] dv);
        dividend = dd;
        divisor  = dv;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Waits for done after a nonzero-divisor launch; optionally re-pulses
    // start (9/3) before edge number poke_at to show it is ignored.
    task automatic wait_result(input string tag, input logic [31:0] dd, input logic [31:0] dv,
                               input int poke_at);
        int  cyc;
        bit  seen;
        logic [31:0] eq;
        logic [31:0] er;
        eq   = dd / dv;
        er   = dd % dv;
        cyc  = 0;
        seen = 1'b0;
        while (cyc < 40 && !seen) begin
            if (cyc + 1 == poke_at) begin
                dividend = 32'd9;
                divisor  = 32'd3;
                start    = 1'b1;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            cyc++;
            if (done) seen = 1'b1;
        end
        check({tag, " latency"}, 64'(cyc), 64'd33);
        check({tag, " quotient"}, 64'(quotient), 64'(eq));
        check({tag, " remainder"}, 64'(remainder), 64'(er));
        check({tag, " dbz"}, 64'(div_by_zero), 64'd0);
        check({tag, " busy_low"}, 64'(busy), 64'd0);
    endtask

    task automatic run_div(input string tag, input logic [31:0] dd, input logic [31:0] dv);
        logic [31:0] dd_q;
        dd_q = dd;
        launch(dd, dv);
        if (dv == 32'd0) begin
            check({tag, " dz_done"}, 64'(done), 64'd1);
            check({tag, " dz_flag"}, 64'(div_by_zero), 64'd1);
            check({tag, " dz_quot"}, 64'(quotient), 64'hFFFF_FFFF);
            check({tag, " dz_rem"}, 64'(remainder), 64'(dd_q));
            check({tag, " dz_busy"}, 64'(busy), 64'd0);
            @(posedge clk);
            #1;
            check({tag, " dz_pulse"}, 64'(done), 64'd0);
            check({tag, " dz_hold"}, 64'(remainder), 64'(dd_q));
        end else begin
            check({tag, " busy"}, 64'(busy), 64'd1);
            wait_result(tag, dd, dv, -1);
            @(posedge clk);
            #1;
            check({tag, " pulse"}, 64'(done), 64'd0);
            check({tag, " hold"}, 64'(quotient), 64'(dd / dv));
        end
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] rv;
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst quotient", 64'(quotient), 64'd0);
        check("rst remainder", 64'(remainder), 64'd0);
        check("rst dbz", 64'(div_by_zero), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_div("basic", 32'd100, 32'd7);
        run_div("max_by_1", 32'hFFFF_FFFF, 32'd1);
        run_div("small", 32'd3, 32'd10);
        run_div("big_div", 32'h8000_0000, 32'hFFFF_FFFF);
        run_div("zero", 32'd5, 32'd0);

        // Start while busy is ignored; start in the done cycle is accepted.
        launch(32'd100, 32'd7);
        wait_result("busy_poke", 32'd100, 32'd7, 10);
        launch(32'd9, 32'd3);
        check("b2b done_clr", 64'(done), 64'd0);
        check("b2b busy", 64'(busy), 64'd1);
        check("b2b hold", 64'(quotient), 64'd14);
        wait_result("b2b", 32'd9, 32'd3, -1);
        @(negedge clk);

        // Reset in the middle of a divide.
        launch(32'd100, 32'd7);
        repeat (14) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst busy", 64'(busy), 64'd0);
        check("mid_rst done", 64'(done), 64'd0);
        check("mid_rst quotient", 64'(quotient), 64'd0);
        check("mid_rst remainder", 64'(remainder), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("mid_rst no_done", 64'(done), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_div("after_rst", 32'd1000, 32'd33);

        for (int i = 0; i < 24; i++) begin
            rd = $urandom;
            rv = $urandom >> $urandom_range(0, 31);
            if (i % 7 == 3) rv = 32'd0;
            if (i % 5 == 1) rv = rv | 32'h8000_0000;
            if (i % 6 == 2) rd = rd >> $urandom_range(0, 31);
            run_div($sformatf("rand%0d", i), rd, rv);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_nr_divider_seq
